// File: rtl/ascii_seq_checker.sv
// Frame checker for NUL-delimited "digits operator letters" ASCII sequences.
// The closing NUL of one frame also opens the next one.
//
// state     | meaning
// ----------+-------------------------------------------------------
// S_IDLE    | waiting for the first NUL after reset
// S_DIGITS  | collecting the digit field
// S_OPER    | operator seen, the first letter is expected next
// S_LETTERS | collecting the letter field
// S_ERROR   | frame already rejected, waiting for the closing NUL
module ascii_seq_checker #(
  parameter int MIN_DIGITS  = 1,
  parameter int MAX_DIGITS  = 4,
  parameter int MIN_LETTERS = 1,
  parameter int MAX_LETTERS = 4,
  parameter int LOWER_OK    = 0,
  localparam int MAX_FIELD  = (MAX_DIGITS > MAX_LETTERS) ? MAX_DIGITS : MAX_LETTERS,
  localparam int CW         = $clog2(MAX_FIELD + 2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    ascii_char,
  input  logic          char_valid,
  output logic          sequence_valid,
  output logic          output_strobe,
  output logic [2:0]    error_code,
  output logic [1:0]    op_code,
  output logic [CW-1:0] digit_count,
  output logic [CW-1:0] letter_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DIGITS  = 3'd1;
  localparam logic [2:0] S_OPER    = 3'd2;
  localparam logic [2:0] S_LETTERS = 3'd3;
  localparam logic [2:0] S_ERROR   = 3'd4;

  localparam logic [2:0] E_NONE   = 3'd0;
  localparam logic [2:0] E_DIGIT  = 3'd1;
  localparam logic [2:0] E_DCOUNT = 3'd2;
  localparam logic [2:0] E_LETTER = 3'd3;
  localparam logic [2:0] E_LCOUNT = 3'd4;

  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] D_MIN = CW'(MIN_DIGITS);
  localparam logic [CW-1:0] D_MAX = CW'(MAX_DIGITS);
  localparam logic [CW-1:0] D_SAT = CW'(MAX_DIGITS + 1);
  localparam logic [CW-1:0] L_MIN = CW'(MIN_LETTERS);
  localparam logic [CW-1:0] L_MAX = CW'(MAX_LETTERS);
  localparam logic [CW-1:0] L_SAT = CW'(MAX_LETTERS + 1);

  logic [2:0]    state, state_n;
  logic [CW-1:0] dcnt, dcnt_n, lcnt, lcnt_n;
  logic [1:0]    op_q, op_n;
  logic [2:0]    err_q, err_n;
  logic          frame_end;
  logic [2:0]    end_code;

  logic       is_nul, is_digit, is_letter, is_op;
  logic [1:0] op_enc;
  logic       d_in_range, l_in_range;

  always_comb begin
    is_nul    = (ascii_char == 8'h00);
    is_digit  = (ascii_char >= 8'h30) && (ascii_char <= 8'h39);
    is_letter = ((ascii_char >= 8'h41) && (ascii_char <= 8'h5A)) ||
                ((LOWER_OK != 0) && (ascii_char >= 8'h61) && (ascii_char <= 8'h7A));
    is_op  = 1'b1;
    op_enc = 2'd0;
    case (ascii_char)
      8'h2B:   op_enc = 2'd0;
      8'h2D:   op_enc = 2'd1;
      8'h2A:   op_enc = 2'd2;
      8'h2F:   op_enc = 2'd3;
      default: is_op = 1'b0;
    endcase
    d_in_range = (dcnt >= D_MIN) && (dcnt <= D_MAX);
    l_in_range = (lcnt >= L_MIN) && (lcnt <= L_MAX);
  end

  always_comb begin
    state_n   = state;
    dcnt_n    = dcnt;
    lcnt_n    = lcnt;
    op_n      = op_q;
    err_n     = err_q;
    frame_end = 1'b0;
    end_code  = err_q;
    if (char_valid) begin
      case (state)
        S_IDLE: begin
          if (is_nul) begin
            state_n = S_DIGITS;
            dcnt_n  = '0;
            lcnt_n  = '0;
            err_n   = E_NONE;
          end
        end
        S_DIGITS: begin
          if (is_digit) begin
            if (dcnt != D_SAT) dcnt_n = dcnt + ONE;
          end else if (is_op) begin
            if (d_in_range) begin
              state_n = S_OPER;
              op_n    = op_enc;
            end else begin
              state_n = S_ERROR;
              err_n   = E_DCOUNT;
            end
          end else if (is_nul && (dcnt == '0)) begin
            // empty frame: reported, and the NUL keeps the next frame open
            frame_end = 1'b1;
            end_code  = E_DIGIT;
          end else begin
            state_n = S_ERROR;
            err_n   = E_DIGIT;
          end
        end
        S_OPER: begin
          if (is_letter) begin
            state_n = S_LETTERS;
            lcnt_n  = ONE;
          end else if (is_nul) begin
            frame_end = 1'b1;
            end_code  = E_LCOUNT;
          end else begin
            state_n = S_ERROR;
            err_n   = E_LETTER;
          end
        end
        S_LETTERS: begin
          if (is_letter) begin
            if (lcnt != L_SAT) lcnt_n = lcnt + ONE;
          end else if (is_nul) begin
            frame_end = 1'b1;
            end_code  = l_in_range ? E_NONE : E_LCOUNT;
          end else begin
            state_n = S_ERROR;
            err_n   = E_LETTER;
          end
        end
        S_ERROR: begin
          if (is_nul) begin
            frame_end = 1'b1;
            end_code  = err_q;
          end
        end
        default: state_n = S_IDLE;
      endcase
      if (frame_end) begin
        state_n = S_DIGITS;
        dcnt_n  = '0;
        lcnt_n  = '0;
        err_n   = E_NONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      dcnt           <= '0;
      lcnt           <= '0;
      op_q           <= 2'd0;
      err_q          <= E_NONE;
      sequence_valid <= 1'b0;
      output_strobe  <= 1'b0;
      error_code     <= E_NONE;
      op_code        <= 2'd0;
      digit_count    <= '0;
      letter_count   <= '0;
    end else begin
      state         <= state_n;
      dcnt          <= dcnt_n;
      lcnt          <= lcnt_n;
      op_q          <= op_n;
      err_q         <= err_n;
      output_strobe <= frame_end;
      if (frame_end) begin
        sequence_valid <= (end_code == E_NONE);
        error_code     <= end_code;
        digit_count    <= dcnt;
        letter_count   <= lcnt;
        if (end_code == E_NONE) op_code <= op_q;
      end
    end
  end

endmodule

// File: tb/tb_ascii_seq_checker.sv
// Directed bench for ascii_seq_checker: default instance plus a LOWER_OK=1 instance on the same stream.
module tb_ascii_seq_checker;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       char_valid = 1'b0;
  logic [7:0] ascii_char = 8'h00;

  logic       d_valid, d_strobe, l_valid, l_strobe;
  logic [2:0] d_code, l_code, d_dc, d_lc, l_dc, l_lc;
  logic [1:0] d_op, l_op;

  int n_cmp = 0;
  int n_err = 0;
  int strobes = 0;
  int exp_strobes = 0;

  ascii_seq_checker dut (
    .clk(clk), .rst(rst), .ascii_char(ascii_char), .char_valid(char_valid),
    .sequence_valid(d_valid), .output_strobe(d_strobe), .error_code(d_code),
    .op_code(d_op), .digit_count(d_dc), .letter_count(d_lc)
  );

  ascii_seq_checker #(.LOWER_OK(1)) dut_lc (
    .clk(clk), .rst(rst), .ascii_char(ascii_char), .char_valid(char_valid),
    .sequence_valid(l_valid), .output_strobe(l_strobe), .error_code(l_code),
    .op_code(l_op), .digit_count(l_dc), .letter_count(l_lc)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (d_strobe) strobes++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] c);
    ascii_char = c;
    char_valid = 1'b1;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    ascii_char = 8'h41;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  // NUL on the bus while char_valid is low must be ignored
  task automatic idle(input int n);
    ascii_char = 8'h00;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // called right after the terminating NUL has been sampled
  task automatic frame(input string tag, input int v, input int code, input int op,
                       input int dc, input int lc);
    exp_strobes++;
    chk({tag, ".strobe"}, 32'(d_strobe), 1);
    chk({tag, ".valid"}, 32'(d_valid), v);
    chk({tag, ".code"}, 32'(d_code), code);
    chk({tag, ".op"}, 32'(d_op), op);
    chk({tag, ".digits"}, 32'(d_dc), dc);
    chk({tag, ".letters"}, 32'(d_lc), lc);
    idle(1);
    chk({tag, ".pulse"}, 32'(d_strobe), 0);
    chk({tag, ".hold"}, 32'(d_valid), v);
    chk({tag, ".count"}, strobes, exp_strobes);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", 32'(d_valid), 0);
    chk("rst.strobe", 32'(d_strobe), 0);
    chk("rst.code", 32'(d_code), 0);
    chk("rst.op", 32'(d_op), 0);
    chk("rst.digits", 32'(d_dc), 0);
    chk("rst.letters", 32'(d_lc), 0);
    rst = 1'b0;

    send_str("7+A");
    idle(1);
    chk("idle_ignore.count", strobes, 0);

    send(8'h00); send_str("123+X"); send(8'h00);
    frame("basic", 1, 0, 0, 3, 1);

    send(8'h00);
    frame("empty", 0, 1, 0, 0, 0);

    send_str("456*ABC"); send(8'h00);
    frame("b2b_a", 1, 0, 2, 3, 3);
    send_str("7/Q"); send(8'h00);
    frame("b2b_b", 1, 0, 3, 1, 1);

    send_str("01A+XX"); send(8'h00);
    frame("bad_digit", 0, 1, 3, 2, 0);

    send_str("12345+A"); send(8'h00);
    frame("dcount5", 0, 2, 3, 5, 0);
    send_str("123456789+A"); send(8'h00);
    frame("dcount_sat", 0, 2, 3, 5, 0);
    send_str("+A"); send(8'h00);
    frame("dcount0", 0, 2, 3, 0, 0);

    send_str("1+"); send(8'h00);
    frame("no_letters", 0, 4, 3, 1, 0);

    send_str("9-ab"); send(8'h00);
    chk("lower.l_valid", 32'(l_valid), 1);
    chk("lower.l_code", 32'(l_code), 0);
    chk("lower.l_op", 32'(l_op), 1);
    chk("lower.l_letters", 32'(l_lc), 2);
    frame("lower", 0, 3, 3, 1, 0);

    send_str("1+ABCDE"); send(8'h00);
    frame("lcount5", 0, 4, 3, 1, 5);
    send_str("1+ABCDEFGHI"); send(8'h00);
    frame("lcount_sat", 0, 4, 3, 1, 5);

    send_str("9999-ZZZZ"); send(8'h00);
    frame("max_fields", 1, 0, 1, 4, 4);

    send_str("12");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst.valid", 32'(d_valid), 0);
    chk("midrst.op", 32'(d_op), 0);
    chk("midrst.digits", 32'(d_dc), 0);
    send_str("5+A");
    idle(1);
    chk("midrst.count", strobes, exp_strobes);
    send(8'h00); send_str("3");
    idle(3);
    send_str("+Z");
    idle(2);
    send(8'h00);
    frame("after_rst", 1, 0, 0, 1, 1);

    send_str("5*A1"); send(8'h00);
    frame("bad_letter", 0, 3, 0, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ascii_seq_checker.md
ASCII_SEQ_CHECKER -- requirements
Module: ascii_seq_checker

Interface
REQ-001 Parameter MIN_DIGITS, default 1: minimum digit-field length accepted.
REQ-002 Parameter MAX_DIGITS, default 4: maximum digit-field length accepted; SHALL be >= MIN_DIGITS and >= 1.
REQ-003 Parameter MIN_LETTERS, default 1: minimum letter-field length accepted.
REQ-004 Parameter MAX_LETTERS, default 4: maximum letter-field length accepted; SHALL be >= MIN_LETTERS and >= 1.
REQ-005 Parameter LOWER_OK, default 0: 1 = 'a'..'z' also legal in the letter field; 0 = only 'A'..'Z'.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 ascii_char  in  8  character byte, sampled only when char_valid=1.
REQ-009 char_valid  in  1  one-cycle strobe; each cycle high delivers one character.
REQ-010 sequence_valid  out  1  verdict of the last completed frame; held until the next output_strobe.
REQ-011 output_strobe  out  1  one-cycle pulse marking a frame verdict update.
REQ-012 error_code  out  3  reason for the last verdict; held with sequence_valid.
REQ-013 op_code  out  2  operator of the last valid frame: 0 '+', 1 '-', 2 '*', 3 '/'.
REQ-014 digit_count  out  CW  digit-field length of the last frame, CW = $clog2(max(MAX_DIGITS,MAX_LETTERS)+2).
REQ-015 letter_count  out  CW  letter-field length of the last frame.

Function
REQ-016 Frame grammar: NUL, digits '0'..'9' (MIN_DIGITS..MAX_DIGITS), one operator from {+,-,*,/}, letters (MIN_LETTERS..MAX_LETTERS), NUL.
REQ-017 States: IDLE, DIGITS, OPER, LETTERS, ERROR; the FSM and counters SHALL advance only on cycles with char_valid=1.
REQ-018 IDLE: NUL -> DIGITS with both counters cleared; any other character is ignored, with no strobe.
REQ-019 DIGITS: digit -> increment digit counter, stay; operator with count in range -> OPER, latch op; operator with count out of range -> ERROR, code 2; NUL or any other character -> ERROR, code 1.
REQ-020 OPER: legal letter -> LETTERS, letter counter = 1; any other non-NUL character -> ERROR, code 3; NUL -> frame end, code 4.
REQ-021 LETTERS: legal letter -> increment letter counter; NUL -> frame end, with code 0 if the count is in range, else code 4; any other character -> ERROR, code 3.
REQ-022 ERROR: non-NUL characters are ignored, the first error code is kept, and NUL -> frame end.
REQ-023 Error codes: 0 none, 1 bad/missing digit, 2 digit count out of range, 3 bad character in letter field, 4 letter count out of range or missing.
REQ-024 Counters SHALL saturate at MAX+1 so an overflow is always detected and never wraps.
REQ-025 Frame end: the cycle after the terminating NUL is sampled, output_strobe=1 for exactly one cycle; sequence_valid=(code==0); error_code, digit_count and letter_count are updated; op_code is updated only if the frame is valid.
REQ-026 The terminating NUL SHALL also open the next frame: the FSM goes to DIGITS with counters cleared, so back-to-back frames share one NUL.
REQ-027 A NUL received as the first character after an opening NUL is a frame end with code 1, and the FSM stays in DIGITS.
REQ-028 Output latency: one clock from sampling the terminating NUL to output_strobe; no combinational path from inputs to outputs.

Reset
REQ-029 When rst=1 at a clock edge, the state SHALL go to IDLE and counters to 0, overriding char_valid that cycle.
REQ-030 Reset values: sequence_valid=0, output_strobe=0, error_code=0, op_code=0, digit_count=0, letter_count=0.
REQ-031 Reset mid-frame SHALL discard the partial frame with no strobe; a later NUL starts a fresh frame.

Verification
REQ-032 Defaults, NUL "123+X" NUL -> one strobe, sequence_valid=1, code 0, op_code 0, digit_count 3, letter_count 1.
REQ-033 Defaults, NUL "456*ABC" NUL "7/Q" NUL -> two strobes, both valid, op_code 2 then 3, letter_count 3 then 1.
REQ-034 Defaults, NUL "01A+XX" NUL -> strobe with sequence_valid=0, code 1; op_code unchanged from the previous value.
REQ-035 Defaults, NUL "12345+A" NUL -> sequence_valid=0, code 2, digit_count 5 (saturated); also NUL "1+" NUL -> code 4.
REQ-036 LOWER_OK=0 then 1, NUL "9-ab" NUL -> code 3 with LOWER_OK=0, valid with LOWER_OK=1.
REQ-037 Defaults, NUL "12", then rst for one cycle, then NUL "3+Z" NUL -> exactly one strobe, valid, digit_count 1; char_valid held low for gaps changes nothing.
